flp_norm_rnd: RTL and testbench
===============================

Name: flp_norm_rnd

Overview:
Multi-cycle normalize-and-round stage that consumes the sign-magnitude sum produced by the FP integer adder: sign, (WIDTH+1)-bit magnitude and zero flag, plus the pre-alignment biased exponent. It produces a packed IEEE-754 single-precision result. Normalization shifts one bit per cycle. Rounding is round-to-nearest-even. A valid/ready handshake is used on both sides. The block sits between the mantissa adder and the FP result register in the FADD/FSUB datapath.

Parameters:
WIDTH, 27, adder magnitude width before carry. Constraint: WIDTH >= 26.
- Input bit WIDTH is the carry-out.
- Bit WIDTH-1 is the hidden bit.
- Bits [WIDTH-2:WIDTH-24] are the 23 fraction bits.
- Bit WIDTH-25 is guard; bit WIDTH-26 is round; bits below that are sticky.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_vld  in  1  input operand valid
o_rdy  out  1  block can accept an operand (state IDLE)
i_sn  in  1  sum sign
i_sg  in  WIDTH+1  sum magnitude
i_zero  in  1  sum is zero
i_exp  in  8  biased exponent for hidden-bit position; 0 is treated as 1
o_vld  out  1  result valid
i_rdy  in  1  downstream accepts result
o_res  out  32  packed float {sign, exp[7:0], frac[22:0]}

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, o_vld=0, o_res=0, internal mag/exp/sign=0. o_rdy=1 in the first cycle after reset.
- A reset asserted mid-operation discards the operation in flight. No output is produced for it.
- Input acceptance: o_rdy = (state==IDLE). An operand is accepted on the edge where i_vld & o_rdy. Inputs are ignored at all other times.
- Internal exponent register: 10-bit signed.
- On accept, latch sign, magnitude and exponent (0 mapped to 1). Next state:
  - i_zero=1 → DONE, with o_res={i_sn,31'b0}. Latency 1.
  - otherwise → NORM.
- NORM, one action per cycle, in priority order:
  - mag[WIDTH]=1: shift right 1, sticky |= shifted-out bit, exp+1 → ROUND.
  - mag[WIDTH-1]=1, or exp==1: → ROUND. The second case is a denormal result.
  - else: shift left 1, exp-1, stay in NORM.
  - At most WIDTH-1 left shifts. A nonzero magnitude with i_zero=0 always terminates.
- ROUND, round-to-nearest-even:
  - inc = G & (R | S | L), where L is the fraction LSB.
  - m24 = {hidden, frac} + inc.
  - Carry-out of m24: m24 >>= 1, exp+1.
  - Exponent field: 0 if the resulting hidden bit is 0 (denormal). A denormal that rounds up into the hidden bit gives exp field 1.
  - exp >= 255: o_res = {sn, 8'hFF, 23'b0} (infinity).
  - Register o_res → DONE.
- DONE: o_vld=1. o_res is held stable until i_rdy. On o_vld & i_rdy → IDLE, and o_vld drops the next cycle.
- No input/output overlap: the next accept is earliest the cycle after the output handshake.
- Latency, accept edge to o_vld high:
  - 1 cycle for zero.
  - 3 cycles with no shift or a carry shift.
  - 3+k cycles with k left shifts.
- NaN/Inf operands are handled upstream and never reach this block.

Decomposition:
- Shared include flp_defs.vh:
  - state encodings (IDLE/NORM/ROUND/DONE, 2-bit)
  - FP32 field widths (EXP_W=8, FRAC_W=23)
  - EXP_MAX=255
  - internal exponent width 10
- One combinational sub-module, flp_rnd_ne: inputs m24, G, R, S; outputs rounded m24 and carry-out. It is reused by the future multiplier path.

Test Plan:
1. i_zero=1, i_sn=1 → o_res=0x80000000, o_vld 1 cycle after accept. Same with i_sn=0 → 0x00000000.
2. i_sg=1<<26, i_exp=127, sn=0 → 0x3F800000 at latency 3. Same with i_sg=1<<27 (carry) → 0x40000000 at latency 3.
3. i_sg=1<<20, i_exp=127 → 6 left shifts → 0x3C800000, o_vld at latency 9, o_rdy low throughout.
4. Rounding, i_exp=127:
   - i_sg=(1<<26)|4 (tie, even LSB) → 0x3F800000.
   - i_sg=(1<<26)|12 (tie, odd LSB) → 0x3F800002.
   - i_sg=(1<<26)|5 (above half) → 0x3F800001.
5. Boundaries:
   - i_exp=254, i_sg=27'h7FFFFFF → round overflow → 0x7F800000.
   - i_exp=1, i_sg=1<<25 → denormal 0x00400000.
   - i_exp=1, i_sg=27'h3FFFFFF → rounds into hidden → 0x00800000.
6. Backpressure and reset:
   - Hold i_rdy=0 for 5 cycles in DONE → o_res and o_vld stable, o_rdy=0.
   - Assert rst during NORM → o_vld=0, o_rdy=1 next cycle, and no stale result appears.

Source files
------------

// File: rtl/flp_norm_rnd_pkg.sv
// Shared definitions for the FP normalize-and-round datapath:
// FSM state encoding, FP32 field widths and internal exponent width.
package flp_norm_rnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned IEXP_W = 10;
  localparam int          EXP_MAX = 255;

endpackage

// File: rtl/flp_norm_rnd_if.sv
// Operand/result handshake bundle between the mantissa adder, the
// normalize-and-round stage and the FP result register.
interface flp_norm_rnd_if #(
  parameter int unsigned WIDTH = 27
);
  logic             i_vld;
  logic             o_rdy;
  logic             i_sn;
  logic [WIDTH:0]   i_sg;
  logic             i_zero;
  logic [7:0]       i_exp;
  logic             o_vld;
  logic             i_rdy;
  logic [31:0]      o_res;

  modport master (
    output i_vld, i_sn, i_sg, i_zero, i_exp, i_rdy,
    input  o_rdy, o_vld, o_res
  );

  modport slave (
    input  i_vld, i_sn, i_sg, i_zero, i_exp, i_rdy,
    output o_rdy, o_vld, o_res
  );
endinterface

// File: rtl/flp_norm_rnd_rnd_ne.sv
// Round-to-nearest-even on a 24-bit significand given guard/round/sticky.
// Combinational; also intended for the multiplier path.
module flp_rnd_ne
  import flp_norm_rnd_pkg::*;
(
  input  logic [FRAC_W:0] m24,
  input  logic            g,
  input  logic            r,
  input  logic            s,
  output logic [FRAC_W:0] m24_rnd,
  output logic            cout
);

  logic inc;

  always_comb begin
    inc = g & (r | s | m24[0]);
    {cout, m24_rnd} = {1'b0, m24} + {{(FRAC_W + 1){1'b0}}, inc};
  end

endmodule

// File: rtl/flp_norm_rnd.sv
// Multi-cycle normalize (one bit per cycle) and round-to-nearest-even stage
// producing a packed FP32 result from the adder's sign-magnitude sum.
module flp_norm_rnd
  import flp_norm_rnd_pkg::*;
#(
  parameter int unsigned WIDTH = 27
) (
  input logic           clk,
  input logic           rst,
  flp_norm_rnd_if.slave bus
);

  // Magnitude is held one bit wider than the input with an extra LSB that
  // catches the bit shifted out by a carry shift, so sticky always exists.
  // Layout: [WIDTH+1]=carry, [WIDTH]=hidden, then 23 frac, G, R, sticky.
  state_t                    state;
  logic [WIDTH+1:0]          mag;
  logic signed [IEXP_W-1:0]  exp_q;
  logic                      sn;
  logic                      vld;
  logic [31:0]               res;

  logic [FRAC_W:0]           m24;
  logic                      g, r, s;
  logic [FRAC_W:0]           rnd;
  logic                      cout;
  logic [FRAC_W:0]           m_fin;
  logic signed [IEXP_W-1:0]  exp_fin;
  logic [EXP_W-1:0]          exp_field;
  logic [31:0]               round_res;

  always_comb begin
    m24 = mag[WIDTH -: (FRAC_W + 1)];
    g   = mag[WIDTH - 24];
    r   = mag[WIDTH - 25];
    s   = |mag[WIDTH - 26:0];
  end

  flp_rnd_ne u_rnd (
    .m24     (m24),
    .g       (g),
    .r       (r),
    .s       (s),
    .m24_rnd (rnd),
    .cout    (cout)
  );

  always_comb begin
    m_fin     = cout ? {1'b1, rnd[FRAC_W:1]} : rnd;
    exp_fin   = cout ? exp_q + 10'sd1 : exp_q;
    // A denormal that rounds up into the hidden bit picks up exp field 1
    // naturally, since its internal exponent is already 1.
    exp_field = m_fin[FRAC_W] ? exp_fin[EXP_W-1:0] : '0;
    if (exp_fin >= 10'(EXP_MAX))
      round_res = {sn, 8'hFF, 23'b0};
    else
      round_res = {sn, exp_field, m_fin[FRAC_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      exp_q <= '0;
      sn    <= 1'b0;
      vld   <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_vld) begin
            sn    <= bus.i_sn;
            mag   <= {bus.i_sg, 1'b0};
            exp_q <= (bus.i_exp == 8'd0) ? 10'sd1 : signed'({2'b00, bus.i_exp});
            if (bus.i_zero) begin
              res   <= {bus.i_sn, 31'b0};
              vld   <= 1'b1;
              state <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[WIDTH+1]) begin
            mag   <= {1'b0, mag[WIDTH+1:2], mag[1] | mag[0]};
            exp_q <= exp_q + 10'sd1;
            state <= ROUND;
          end else if (mag[WIDTH] || exp_q == 10'sd1) begin
            state <= ROUND;
          end else begin
            mag   <= {mag[WIDTH:0], 1'b0};
            exp_q <= exp_q - 10'sd1;
          end
        end
        ROUND: begin
          res   <= round_res;
          vld   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.i_rdy) begin
            vld   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_rdy = (state == IDLE);
  assign bus.o_vld = vld;
  assign bus.o_res = res;

endmodule

// File: tb/tb_flp_norm_rnd.sv
// Directed self-checking bench for flp_norm_rnd with hand-computed results.
module tb_flp_norm_rnd;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  flp_norm_rnd_if #(.WIDTH(27)) bus ();

  flp_norm_rnd #(.WIDTH(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand, waits (bounded) for o_vld, captures result and
  // latency in clock edges counted from the accept edge, then handshakes.
  task automatic run_op(input logic sn, input logic [27:0] sg, input logic zero,
                        input logic [7:0] ex, output logic [31:0] res,
                        output int lat, output logic rdy_low);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.o_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.i_sn   = sn;
    bus.i_sg   = sg;
    bus.i_zero = zero;
    bus.i_exp  = ex;
    bus.i_rdy  = 1'b0;
    bus.i_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    while (!bus.o_vld && lat < 100) begin
      if (bus.o_rdy) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.o_rdy) rdy_low = 1'b0;
    res = bus.o_res;
    @(negedge clk);
    bus.i_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", bus.o_vld); end
    n_checks++;
    if (bus.o_res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 00000000", bus.o_res); end
    n_checks++;
    if (bus.o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", bus.o_rdy); end
  endtask

  task automatic test_zero();
    logic [31:0] res;
    int lat;
    logic rl;
    run_op(1'b1, 28'h0, 1'b1, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h80000000) begin n_fail++; $display("FAIL zero_neg got %h want 80000000", res); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL zero_neg_lat got %0d want 1", lat); end
    run_op(1'b0, 28'h0, 1'b1, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h00000000) begin n_fail++; $display("FAIL zero_pos got %h want 00000000", res); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL zero_pos_lat got %0d want 1", lat); end
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int lat;
    logic rl;
    run_op(1'b0, 28'h4000000, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800000) begin n_fail++; $display("FAIL one got %h want 3F800000", res); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL one_lat got %0d want 3", lat); end
    run_op(1'b0, 28'h8000000, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h40000000) begin n_fail++; $display("FAIL carry got %h want 40000000", res); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL carry_lat got %0d want 3", lat); end
    run_op(1'b1, 28'h4000000, 1'b0, 8'd0, res, lat, rl);
    n_checks++;
    if (res !== 32'h80800000) begin n_fail++; $display("FAIL exp0_as_1 got %h want 80800000", res); end
  endtask

  task automatic test_shift();
    logic [31:0] res;
    int lat;
    logic rl;
    run_op(1'b0, 28'h0100000, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3C800000) begin n_fail++; $display("FAIL shift6 got %h want 3C800000", res); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL shift6_lat got %0d want 9", lat); end
    n_checks++;
    if (rl !== 1'b1) begin n_fail++; $display("FAIL shift6_rdy_low got %b want 1", rl); end
  endtask

  task automatic test_rounding();
    logic [31:0] res;
    int lat;
    logic rl;
    run_op(1'b0, 28'h4000004, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800000) begin n_fail++; $display("FAIL tie_even got %h want 3F800000", res); end
    run_op(1'b0, 28'h400000C, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800002) begin n_fail++; $display("FAIL tie_odd got %h want 3F800002", res); end
    run_op(1'b0, 28'h4000005, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800001) begin n_fail++; $display("FAIL above_half got %h want 3F800001", res); end
    run_op(1'b0, 28'h4000003, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800000) begin n_fail++; $display("FAIL below_half got %h want 3F800000", res); end
    // carry shift pushes the old bit 0 into sticky, making a tie round up
    run_op(1'b0, 28'h8000009, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h40000001) begin n_fail++; $display("FAIL carry_sticky got %h want 40000001", res); end
  endtask

  task automatic test_boundaries();
    logic [31:0] res;
    int lat;
    logic rl;
    run_op(1'b0, 28'h7FFFFFF, 1'b0, 8'd254, res, lat, rl);
    n_checks++;
    if (res !== 32'h7F800000) begin n_fail++; $display("FAIL overflow got %h want 7F800000", res); end
    run_op(1'b0, 28'h2000000, 1'b0, 8'd1, res, lat, rl);
    n_checks++;
    if (res !== 32'h00400000) begin n_fail++; $display("FAIL denormal got %h want 00400000", res); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL denormal_lat got %0d want 3", lat); end
    run_op(1'b0, 28'h3FFFFFF, 1'b0, 8'd1, res, lat, rl);
    n_checks++;
    if (res !== 32'h00800000) begin n_fail++; $display("FAIL denorm_to_norm got %h want 00800000", res); end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clk);
    bus.i_sn   = 1'b0;
    bus.i_sg   = 28'h4000005;
    bus.i_zero = 1'b0;
    bus.i_exp  = 8'd127;
    bus.i_rdy  = 1'b0;
    bus.i_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    w = 0;
    while (!bus.o_vld && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.o_res !== 32'h3F800001 || bus.o_vld !== 1'b1 || bus.o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d got res=%h vld=%b rdy=%b want res=3F800001 vld=1 rdy=0",
                 i, bus.o_res, bus.o_vld, bus.o_rdy);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.i_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b0;
    n_checks++;
    if (bus.o_vld !== 1'b0 || bus.o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL release got vld=%b rdy=%b want vld=0 rdy=1", bus.o_vld, bus.o_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [31:0] res;
    int lat;
    logic rl;
    @(negedge clk);
    bus.i_sn   = 1'b0;
    bus.i_sg   = 28'h0100000;
    bus.i_zero = 1'b0;
    bus.i_exp  = 8'd127;
    bus.i_rdy  = 1'b1;
    bus.i_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_vld !== 1'b0 || bus.o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst got vld=%b rdy=%b want vld=0 rdy=1", bus.o_vld, bus.o_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_vld) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got vld_seen=%b want 0", seen); end
    bus.i_rdy = 1'b0;
    run_op(1'b0, 28'h4000000, 1'b0, 8'd127, res, lat, rl);
    n_checks++;
    if (res !== 32'h3F800000) begin n_fail++; $display("FAIL after_rst got %h want 3F800000", res); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.i_vld  = 1'b0;
    bus.i_sn   = 1'b0;
    bus.i_sg   = '0;
    bus.i_zero = 1'b0;
    bus.i_exp  = '0;
    bus.i_rdy  = 1'b0;
    test_reset();
    test_zero();
    test_basic();
    test_shift();
    test_rounding();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
